// File: rtl/alu_share_arbiter.sv
// Round-robin front end that time-shares one external combinational ALU
// between NUM_REQ requesters; one operation in flight at a time.
module alu_share_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  localparam int IDW          = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srca,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srcb,
  input  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op,
  output logic [NUM_REQ-1:0]               rsp_valid,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [DATA_WIDTH-1:0]            alu_srca,
  output logic [DATA_WIDTH-1:0]            alu_srcb,
  output logic [OPCODE_LENGTH-1:0]         alu_op,
  input  logic [DATA_WIDTH-1:0]            alu_result,
  output logic                             busy,
  output logic [IDW-1:0]                   gnt_id
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]     state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] win_id;
  logic           win_found;

  // Rotating priority: first valid bit strictly after last_grant, wrapping.
  always_comb begin
    logic [IDW-1:0] idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(last_grant) + k) % NUM_REQ);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // req_ready is gated by rst_n so it reads zero while reset is held.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = rst_n && (state == S_IDLE) && win_found && (win_id == IDW'(i));
      rsp_valid[i] = (state == S_RESP) && (gnt_id == IDW'(i));
    end
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      alu_srca   <= '0;
      alu_srcb   <= '0;
      alu_op     <= '0;
      rsp_data   <= '0;
      gnt_id     <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            alu_srca   <= req_srca[win_id*DATA_WIDTH +: DATA_WIDTH];
            alu_srcb   <= req_srcb[win_id*DATA_WIDTH +: DATA_WIDTH];
            alu_op     <= req_op[win_id*OPCODE_LENGTH +: OPCODE_LENGTH];
            gnt_id     <= win_id;
            last_grant <= win_id;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_data <= alu_result;
          state    <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready[gnt_id]) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench: table of single-requester ops, then round robin,
// backpressure and mid-operation reset sequences, all scored through a queue.
module tb_alu_share_arbiter;

  localparam int NR = 3;
  localparam int DW = 32;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*DW-1:0] req_srca, req_srcb;
  logic [NR*OW-1:0] req_op;
  logic [DW-1:0] rsp_data, alu_srca, alu_srcb, alu_result;
  logic [OW-1:0] alu_op;
  logic          busy;
  logic [1:0]    gnt_id;

  alu_share_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_srca(req_srca), .req_srcb(req_srcb), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op),
    .alu_result(alu_result), .busy(busy), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  // Environment ALU standing in for the parent's instance.
  function automatic logic [31:0] alu_model(input logic [31:0] a, b, input logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a + b;
      4'b0010: return a | b;
      4'b0011: return a - b;
      4'b0100: return a ^ b;
      4'b1010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_result = alu_model(alu_srca, alu_srcb, alu_op);

  typedef struct { int id; logic [31:0] data; } exp_t;
  typedef struct { int id; logic [31:0] a; logic [31:0] b; logic [3:0] op; logic [31:0] exp; } vec_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] oh(input int id);
    logic [31:0] one;
    one = 32'd1;
    return one << id;
  endfunction

  // Scoreboard: every response handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && |(rsp_valid & rsp_ready)) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_valid_id", 32'(rsp_valid), oh(e.id));
        chk("rsp_gnt_id", 32'(gnt_id), 32'(e.id));
        chk("rsp_data", rsp_data, e.data);
      end
    end
  end

  task automatic set_req(input int id, input logic [31:0] a, b, input logic [3:0] op);
    req_srca[id*DW +: DW] = a;
    req_srcb[id*DW +: DW] = b;
    req_op[id*OW +: OW]   = op;
  endtask

  task automatic push(input int id, input logic [31:0] d);
    exp_t e;
    e.id = id;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input int budget);
    int c;
    c = 0;
    while (sb.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("sb_drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Lone request, called right after a rising edge with the FSM idle.
  task automatic do_op(input vec_t v);
    set_req(v.id, v.a, v.b, v.op);
    req_valid = NR'(oh(v.id));
    rsp_ready = '1;
    push(v.id, v.exp);
    @(negedge clk);
    chk("acc_ready", 32'(req_ready), oh(v.id));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_ready0", 32'(req_ready), 32'd0);
    chk("exec_srca", alu_srca, v.a);
    chk("exec_srcb", alu_srcb, v.b);
    chk("exec_op", 32'(alu_op), 32'(v.op));
    @(negedge clk);
    chk("resp_valid", 32'(rsp_valid), oh(v.id));
    chk("resp_gnt", 32'(gnt_id), 32'(v.id));
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{id: 1, a: 32'd5,          b: 32'd7,      op: 4'b0001, exp: 32'd12};
    vecs[1] = '{id: 0, a: 32'd0,          b: 32'd1,      op: 4'b0011, exp: 32'hFFFF_FFFF};
    vecs[2] = '{id: 0, a: 32'd9,          b: 32'd9,      op: 4'b1111, exp: 32'd0};
    vecs[3] = '{id: 0, a: 32'd3,          b: 32'd4,      op: 4'b1010, exp: 32'd1};
    vecs[4] = '{id: 2, a: 32'h0000_F0F0,  b: 32'h0000_0FF0, op: 4'b0000, exp: 32'h0000_00F0};
    vecs[5] = '{id: 1, a: 32'h8000_0000,  b: 32'd1,      op: 4'b1010, exp: 32'd1};
    vecs[6] = '{id: 2, a: 32'd7,          b: 32'd3,      op: 4'b0100, exp: 32'd4};

    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_srca = '0;
    req_srcb = '0;
    req_op = '0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_alu_srca", alu_srca, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt_id", 32'(gnt_id), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) do_op(vecs[i]);

    // Round robin: last grant was requester 2, so expect 0,1,2,0.
    set_req(0, 32'd5, 32'd3, 4'b0001);
    set_req(1, 32'd10, 32'd4, 4'b0011);
    set_req(2, 32'd6, 32'd3, 4'b0100);
    push(0, 32'd8); push(1, 32'd6); push(2, 32'd5); push(0, 32'd8);
    req_valid = '1;
    rsp_ready = '1;
    for (int g = 0; g < 4; g++) begin
      int c;
      int exp_id;
      exp_id = g % NR;
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (req_ready == '0 && c < 20);
      chk("rr_grant", 32'(req_ready), oh(exp_id));
      @(posedge clk); #1;
      if (g == 3) req_valid = '0;
    end
    wait_empty(20);

    // Backpressure on requester 2 while requester 0 waits.
    set_req(2, 32'd100, 32'd1, 4'b0011);
    push(2, 32'd99);
    req_valid = 3'b100;
    rsp_ready = '0;
    @(negedge clk);
    chk("bp_acc", 32'(req_ready), oh(2));
    @(posedge clk); #1;
    set_req(0, 32'd2, 32'd2, 4'b0001);
    push(0, 32'd4);
    req_valid = 3'b001;
    @(negedge clk);
    chk("bp_exec_ready0", 32'(req_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), oh(2));
      chk("bp_rsp_data", rsp_data, 32'd99);
      chk("bp_ready0", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    rsp_ready = '1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_grant", 32'(req_ready), oh(0));
    @(posedge clk); #1;
    req_valid = '0;
    wait_empty(10);

    // Reset during EXEC: last grant was 0, so requester 1 wins first.
    set_req(0, 32'd1, 32'd1, 4'b0001);
    set_req(1, 32'd4, 32'd4, 4'b0001);
    set_req(2, 32'd5, 32'd5, 4'b0001);
    req_valid = '1;
    @(negedge clk);
    chk("mr_pre_grant", 32'(req_ready), oh(1));
    @(posedge clk); #2;
    chk("mr_exec_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_req_ready", 32'(req_ready), 32'd0);
    chk("mr_alu_srca", alu_srca, 32'd0);
    chk("mr_alu_srcb", alu_srcb, 32'd0);
    chk("mr_rsp_data", rsp_data, 32'd0);
    chk("mr_gnt_id", 32'(gnt_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(0, 32'd2);
    #1;
    chk("mr_first_grant", 32'(req_ready), oh(0));
    @(posedge clk); #1;
    req_valid = '0;
    wait_empty(10);
    repeat (3) @(negedge clk);
    chk("end_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one combinational ALU instance between NUM_REQ requesters, such as an integer pipe, an address-generation helper and a debug port. A round-robin arbiter grants one request at a time and registers that requester's operands and 4-bit opcode onto the ALU inputs. The block then captures the ALU result and returns it to the granted requester with a valid/ready handshake. The block sits beside the ALU in the datapath. The ALU is instantiated by the parent, and its SrcA/SrcB/Operation/ALUResult nets connect to this block's alu_* ports.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
DATA_WIDTH, 32, operand/result width; must match the ALU
OPCODE_LENGTH, 4, ALU operation code width; must match the ALU

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  request i presents an operation
req_ready  output  NUM_REQ  one-hot; request i accepted this cycle
req_srca  input  NUM_REQ*DATA_WIDTH  operand A; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_srcb  input  NUM_REQ*DATA_WIDTH  operand B, same packing
req_op  input  NUM_REQ*OPCODE_LENGTH  opcode; requester i at [i*OPCODE_LENGTH +: OPCODE_LENGTH]
rsp_valid  output  NUM_REQ  one-hot; result available for requester i
rsp_ready  input  NUM_REQ  requester i consumes result
rsp_data  output  DATA_WIDTH  result, shared by all requesters
alu_srca  output  DATA_WIDTH  to ALU SrcA
alu_srcb  output  DATA_WIDTH  to ALU SrcB
alu_op  output  OPCODE_LENGTH  to ALU Operation
alu_result  input  DATA_WIDTH  from ALU ALUResult
busy  output  1  high in EXEC or RESP
gnt_id  output  $clog2(NUM_REQ)  index of the current or last granted requester

Behaviour:
- Single clock. Reset is asynchronous and active-low: all flops clear immediately on rst_n=0, and the block leaves reset on the first rising clk edge with rst_n=1.
- Reset values:
  - state=IDLE.
  - alu_srca=0, alu_srcb=0, alu_op=0.
  - rsp_data=0, rsp_valid=0, req_ready=0, busy=0.
  - gnt_id=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
- FSM has three states: IDLE, EXEC, RESP. At most one operation is outstanding.
- IDLE:
  - If any req_valid bit is set, the winner is the first set bit scanning from last_grant+1 upward, modulo NUM_REQ.
  - req_ready[winner] is driven combinationally high in the same cycle. All other req_ready bits are 0.
  - On the clock edge: alu_srca, alu_srcb and alu_op load from the winner's slices; gnt_id and last_grant load the winner; state goes to EXEC.
  - req_ready is 0 in every state other than IDLE.
- EXEC (exactly 1 cycle): alu_* are stable from registers. On the clock edge rsp_data loads alu_result and state goes to RESP.
- RESP:
  - rsp_valid[gnt_id]=1; all other rsp_valid bits are 0. rsp_data is held stable.
  - When rsp_ready[gnt_id]=1: rsp_valid drops on the next edge and state goes to IDLE.
  - rsp_ready on non-granted bits is ignored.
- Latency: request accept edge to rsp_valid high is 2 cycles. Minimum issue interval is 3 cycles per operation when rsp_ready is held high.
- alu_* and rsp_data hold their last values outside the states that load them. They never return to 0 except on reset.
- The block does not interpret or modify opcodes or data. Unsupported opcodes pass straight to the ALU, and the ALU's output (0 for its default case) is returned unchanged.
- A requester may drop req_valid before it is granted with no effect. Once granted, that requester's inputs are not sampled again.
- Simultaneous req_valid from the granted requester while in RESP is not accepted until the FSM is back in IDLE. Round-robin ordering then moves priority past that requester.
- Reset asserted in EXEC or RESP aborts the operation: no rsp_valid pulse follows, and priority restarts at requester 0.

Test Plan:
1. Single ADD: requester 1 sends srca=5, srcb=7, op=0001 with rsp_ready=1 -> req_ready=3'b010 for one cycle; 2 cycles later rsp_valid=3'b010, rsp_data=12, gnt_id=1.
2. SUB wrap: requester 0 sends srca=0, srcb=1, op=0011 -> rsp_data=32'hFFFFFFFF.
3. Round robin: all three req_valid held high, each with a distinct op -> grant order 0,1,2,0. Each rsp_data matches that requester's operation. No requester is granted twice in a row while others are pending.
4. Backpressure: during RESP for requester 2, rsp_ready held 0 for 4 cycles while req_valid[0]=1 -> rsp_valid and rsp_data stay constant, req_ready stays 0, busy=1. After rsp_ready=1, requester 0 is granted in the following IDLE cycle.
5. Reset mid-op: rst_n pulled low asynchronously during EXEC -> all outputs go to 0 immediately. After release, no stale rsp_valid appears, and with all requests pending requester 0 is granted first.
6. Unsupported opcode: requester 0 sends op=1111, srca=9, srcb=9 -> rsp_data=0. SLT-style op=1010 with srca=3, srcb=4 -> rsp_data=1.
